// File: rtl/dsp_pkg.sv
// Shared DSP constants: default word width, legal comb/decimation limits and
// a constant clog2 used to size phase counters.
package dsp_pkg;

  localparam int WORD_LENGTH_DEFAULT = 8;
  localparam int STAGES_MIN          = 1;
  localparam int STAGES_MAX          = 8;
  localparam int DECIMATION_MIN      = 1;
  localparam int DECIMATION_MAX      = 256;

  function automatic int clog2(input int value);
    int bits;
    int rem;
    bits = 0;
    rem  = value - 1;
    while (rem > 0) begin
      bits = bits + 1;
      rem  = rem >>> 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/comb_stage.sv
// One first-difference stage: y = x - x_previous, where the delay register
// only advances on enabled (decimated) cycles.
module comb_stage
  import dsp_pkg::*;
#(
  parameter int word_length = WORD_LENGTH_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [word_length-1:0] x,
  output logic [word_length-1:0] y
);

  logic signed [word_length-1:0] d;

  // Two's-complement wrap is intentional: integrator overflow cancels here.
  assign y = $unsigned($signed(x) - d);

  always_ff @(posedge clock) begin
    if (reset) begin
      d <= '0;
    end else if (enable) begin
      d <= $signed(x);
    end
  end

endmodule

// File: rtl/comb_decimator.sv
// Decimating CIC comb section: keeps every decimation-th input word and runs
// it through a combinational cascade of first-difference stages.
module comb_decimator
  import dsp_pkg::*;
#(
  parameter int word_length = WORD_LENGTH_DEFAULT,
  parameter int stages      = 2,
  parameter int decimation  = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [word_length-1:0] data_in,
  input  logic                   hold,
  output logic [word_length-1:0] data_out,
  output logic                   valid_out
);

  localparam int COUNT_W = (clog2(decimation) < 1) ? 1 : clog2(decimation);
  localparam logic [COUNT_W-1:0] LAST = COUNT_W'(decimation - 1);

  logic [COUNT_W-1:0]                count;
  logic                              accept;
  logic [stages:0][word_length-1:0]  chain;

  assign accept   = !reset && !hold && (count == LAST);
  assign chain[0] = data_in;

  for (genvar k = 0; k < stages; k++) begin : g_stage
    comb_stage #(
      .word_length(word_length)
    ) u_stage (
      .clock  (clock),
      .reset  (reset),
      .enable (accept),
      .x      (chain[k]),
      .y      (chain[k+1])
    );
  end

  // Output register: updated only on the accept edge, strobe otherwise low.
  always_ff @(posedge clock) begin
    if (reset) begin
      count     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else if (hold) begin
      valid_out <= 1'b0;
    end else if (count == LAST) begin
      count     <= '0;
      data_out  <= chain[stages];
      valid_out <= 1'b1;
    end else begin
      count     <= count + COUNT_W'(1);
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_comb_decimator.sv
// Bench for comb_decimator: four configurations share one stimulus stream and
// are checked against a binomial-sum reference model plus directed values.
module tb_comb_decimator;

  logic       clk;
  logic       rst;
  logic       hold;
  logic [7:0] din;
  logic [7:0] dout [4];
  logic       vout [4];

  int compared   = 0;
  int mismatched = 0;

  int        ss [4] = '{1, 2, 1, 2};
  int        rr [4] = '{1, 1, 4, 4};
  int        hs [4][9];
  int        np [4];
  logic [7:0] eo [4];
  logic       ev [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  comb_decimator #(.word_length(8), .stages(1), .decimation(1)) u_s1r1 (
    .clock(clk), .reset(rst), .data_in(din), .hold(hold),
    .data_out(dout[0]), .valid_out(vout[0]));
  comb_decimator #(.word_length(8), .stages(2), .decimation(1)) u_s2r1 (
    .clock(clk), .reset(rst), .data_in(din), .hold(hold),
    .data_out(dout[1]), .valid_out(vout[1]));
  comb_decimator #(.word_length(8), .stages(1), .decimation(4)) u_s1r4 (
    .clock(clk), .reset(rst), .data_in(din), .hold(hold),
    .data_out(dout[2]), .valid_out(vout[2]));
  comb_decimator #(.word_length(8), .stages(2), .decimation(4)) u_s2r4 (
    .clock(clk), .reset(rst), .data_in(din), .hold(hold),
    .data_out(dout[3]), .valid_out(vout[3]));

  function automatic int binom(input int n, input int k);
    int b;
    b = 1;
    for (int j = 0; j < k; j++) b = b * (n - j) / (j + 1);
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output after S differences = sum_j (-1)^j C(S,j) x[m-j], samples before reset = 0.
  task automatic model_update();
    int acc;
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        for (int j = 0; j < 9; j++) hs[i][j] = 0;
        np[i] = 0;
        eo[i] = 8'h00;
        ev[i] = 1'b0;
      end else if (hold) begin
        ev[i] = 1'b0;
      end else begin
        np[i]++;
        if (np[i] % rr[i] == 0) begin
          for (int j = 8; j > 0; j--) hs[i][j] = hs[i][j-1];
          hs[i][0] = int'(din);
          acc = 0;
          for (int j = 0; j <= ss[i]; j++)
            acc += (((j % 2) == 1) ? -1 : 1) * binom(ss[i], j) * hs[i][j];
          eo[i] = acc[7:0];
          ev[i] = 1'b1;
        end else begin
          ev[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic h, input logic [7:0] d);
    rst  = r;
    hold = h;
    din  = d;
    @(posedge clk);
    #1;
    model_update();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("model_out%0d", i), 32'(dout[i]), 32'(eo[i]));
      chk($sformatf("model_vld%0d", i), 32'(vout[i]), 32'(ev[i]));
    end
  endtask

  logic [7:0] t1_in  [4] = '{8'h08, 8'h2f, 8'hff, 8'haa};
  logic [7:0] t1_out [4] = '{8'h08, 8'h27, 8'hd0, 8'hab};
  logic [7:0] t2_in  [5] = '{8'd0, 8'd1, 8'd3, 8'd6, 8'd10};
  logic [7:0] t2_out [5] = '{8'd0, 8'd1, 8'd1, 8'd1, 8'd1};
  logic [7:0] t6_in  [4] = '{8'hfe, 8'hff, 8'h00, 8'h01};
  logic [7:0] t6_out [4] = '{8'hfe, 8'h03, 8'h00, 8'h00};

  initial begin
    rst = 1'b1; hold = 1'b0; din = 8'h00;
    for (int i = 0; i < 4; i++) np[i] = 0;

    // Reset state
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    chk("reset_dout", 32'(dout[3]), 32'h0);
    chk("reset_vld", 32'(vout[3]), 32'h0);

    // First difference, no decimation
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, t1_in[k]);
      chk($sformatf("t1_dout%0d", k), 32'(dout[0]), 32'(t1_out[k]));
      chk($sformatf("t1_vld%0d", k), 32'(vout[0]), 32'h1);
    end

    // Second difference of a quadratic
    step(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, t2_in[k]);
      chk($sformatf("t2_dout%0d", k), 32'(dout[1]), 32'(t2_out[k]));
    end

    // Decimate-by-4 of an integrated constant 3
    step(1'b1, 1'b0, 8'h00);
    for (int n = 1; n <= 12; n++) begin
      step(1'b0, 1'b0, 8'(3 * n));
      chk($sformatf("t3_vld%0d", n), 32'(vout[2]), 32'((n % 4) == 0));
      if ((n % 4) == 0) chk($sformatf("t3_dout%0d", n), 32'(dout[2]), 32'd12);
    end

    // Hold at count=2 for five cycles, then hold exactly on count=3
    step(1'b0, 1'b0, 8'd39);
    step(1'b0, 1'b0, 8'd42);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, 8'd45);
      chk("t4_hold_vld", 32'(vout[2]), 32'h0);
      chk("t4_hold_dout", 32'(dout[2]), 32'd12);
    end
    step(1'b0, 1'b0, 8'd45);
    chk("t4_rel1_vld", 32'(vout[2]), 32'h0);
    step(1'b0, 1'b0, 8'd48);
    chk("t4_rel2_vld", 32'(vout[2]), 32'h1);
    chk("t4_rel2_dout", 32'(dout[2]), 32'd12);
    step(1'b0, 1'b0, 8'd51);
    step(1'b0, 1'b0, 8'd54);
    step(1'b0, 1'b0, 8'd57);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 8'd60);
      chk("t4_hold3_vld", 32'(vout[2]), 32'h0);
    end
    step(1'b0, 1'b0, 8'd60);
    chk("t4_drop_vld", 32'(vout[2]), 32'h1);
    chk("t4_drop_dout", 32'(dout[2]), 32'd12);

    // Reset mid-frame at count=2
    step(1'b0, 1'b0, 8'd63);
    step(1'b0, 1'b0, 8'd66);
    step(1'b1, 1'b0, 8'd69);
    chk("t5_rst_dout", 32'(dout[2]), 32'h0);
    chk("t5_rst_vld", 32'(vout[2]), 32'h0);
    for (int c = 1; c <= 8; c++) begin
      step(1'b0, 1'b0, 8'd5);
      chk($sformatf("t5_vld%0d", c), 32'(vout[2]), 32'((c % 4) == 0));
      if (c == 4) chk("t5_dout4", 32'(dout[2]), 32'd5);
      if (c == 8) chk("t5_dout8", 32'(dout[2]), 32'd0);
    end

    // Wrapping ramp through two stages
    step(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, t6_in[k]);
      chk($sformatf("t6_dout%0d", k), 32'(dout[1]), 32'(t6_out[k]));
    end

    // Random data, holds and occasional resets
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 3) == 0), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
